// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the 32x64 LEGv8 register file
package regfile_pkg;
   localparam int REG_DATA_W = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS = 32;
   localparam logic [4:0] ZERO_REG = 5'd31;
   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: read/write port bundle between the decode stage and the register file
interface regfile_if;
   import regfile_pkg::*;
   reg_idx_t ReadRegister1;
   reg_idx_t ReadRegister2;
   reg_idx_t WriteRegister;
   reg_data_t WriteData;
   logic RegWrite;
   reg_data_t ReadData1;
   reg_data_t ReadData2;
   modport master (
      output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
      input ReadData1, ReadData2
   );
   modport slave (
      input ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
      output ReadData1, ReadData2
   );
endinterface

// File: rtl/regfile_decoder.sv
// regfile_decoder: one-hot write enable from the write index; XZR never enabled
module regfile_decoder
   import regfile_pkg::*;
(
   input  reg_idx_t idx,
   input  logic en,
   output logic [NUM_REGS-1:0] we
);
   logic [NUM_REGS-1:0] dec;
   // one-hot decode, then drop the XZR slot so writes to 31 vanish
   always_comb begin
      dec = en ? (NUM_REGS'(1) << idx) : '0;
      we = {1'b0, dec[NUM_REGS-2:0]};
   end
endmodule

// File: rtl/regfile.sv
// regfile: 32x64 register file, two combinational reads, one synchronous write, X31 reads zero
// Build option: define REGFILE_BYPASS_EN to forward WriteData to a read port addressing the write target
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_W,
   parameter int ADDR_WIDTH = REG_ADDR_W
) (
   input logic clk,
   input logic reset,
   regfile_if.slave bus
);
   localparam int ENTRIES = 2 ** ADDR_WIDTH;
   logic [ENTRIES-1:0] we;
   logic [DATA_WIDTH-1:0] regs [ENTRIES];
   logic fwd1, fwd2;

   regfile_decoder u_dec (
      .idx(bus.WriteRegister),
      .en (bus.RegWrite),
      .we (we)
   );

   for (genvar g = 0; g < ENTRIES; g++) begin : g_reg
      if (g == int'(ZERO_REG)) begin : g_zero
         assign regs[g] = {DATA_WIDTH{1'b0}} & {DATA_WIDTH{we[g]}};
      end else begin : g_store
         logic [DATA_WIDTH-1:0] q;
         // reset clears at once; otherwise load when this entry is selected
         always_ff @(posedge clk or posedge reset)
            if (reset) q <= '0;
            else if (we[g]) q <= bus.WriteData;
         assign regs[g] = q;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // forward the in-flight write to a matching read port, never during reset or to XZR
   always_comb begin
      fwd1 = !reset && bus.RegWrite && bus.WriteRegister != ZERO_REG && bus.ReadRegister1 == bus.WriteRegister;
      fwd2 = !reset && bus.RegWrite && bus.WriteRegister != ZERO_REG && bus.ReadRegister2 == bus.WriteRegister;
   end
`else
   // no forwarding: reads see the stored value until the edge
   always_comb begin
      fwd1 = 1'b0;
      fwd2 = 1'b0;
   end
`endif

   // zero-latency read muxes; entry 31 is the tied-off zero
   always_comb begin
      bus.ReadData1 = fwd1 ? bus.WriteData : regs[bus.ReadRegister1];
      bus.ReadData2 = fwd2 ? bus.WriteData : regs[bus.ReadRegister2];
   end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile
module tb_regfile;
   localparam logic [63:0] P = 64'h0000010204080001;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int passed = 0;

   regfile_if bus ();

   regfile dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pat(input int i);
      return (i == 31) ? 64'h0 : 64'(i) * P;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      bus.RegWrite = 1'b1;
      bus.WriteRegister = 5'd4;
      bus.WriteData = 64'hFF;
      bus.ReadRegister1 = 5'd4;
      bus.ReadRegister2 = 5'd31;
      #1;
      check("reset_rd1", bus.ReadData1, 64'h0);
      check("reset_rd2", bus.ReadData2, 64'h0);
      tick();
      check("write_in_reset_ignored", bus.ReadData1, 64'h0);
      reset = 1'b0;
      bus.RegWrite = 1'b0;
      tick();
      check("x4_after_release", bus.ReadData1, 64'h0);
      bus.WriteRegister = 5'd31;
      bus.WriteData = 64'hA0;
      bus.RegWrite = 1'b1;
      bus.ReadRegister1 = 5'd31;
      tick();
      bus.RegWrite = 1'b0;
      #1;
      check("x31_protect", bus.ReadData1, 64'h0);
      for (int i = 0; i < 31; i++) begin
         bus.WriteRegister = 5'(i);
         bus.WriteData = pat(i);
         bus.RegWrite = 1'b1;
         tick();
      end
      bus.RegWrite = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bus.ReadRegister1 = 5'((i + 31) % 32);
         bus.ReadRegister2 = 5'(i);
         #1;
         check($sformatf("fill_p1_%0d", (i + 31) % 32), bus.ReadData1, pat((i + 31) % 32));
         check($sformatf("fill_p2_%0d", i), bus.ReadData2, pat(i));
      end
      bus.ReadRegister1 = 5'd30;
      #1;
      check("x30_literal", bus.ReadData1, 64'h00001E3C78F0001E);
      bus.WriteRegister = 5'd5;
      bus.WriteData = 64'hDEADBEEF;
      bus.ReadRegister2 = 5'd5;
      repeat (3) tick();
      check("we_low_x5_kept", bus.ReadData2, 64'h0000050A14280005);
      bus.WriteRegister = 5'd7;
      bus.WriteData = 64'h7;
      bus.RegWrite = 1'b1;
      tick();
      bus.WriteData = 64'h1234;
      bus.ReadRegister1 = 5'd7;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("same_cycle_before", bus.ReadData1, 64'h1234);
`else
      check("same_cycle_before", bus.ReadData1, 64'h7);
`endif
      tick();
      bus.RegWrite = 1'b0;
      check("same_cycle_after", bus.ReadData1, 64'h1234);
      #2;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) begin
         bus.ReadRegister1 = 5'(i);
         bus.ReadRegister2 = 5'(31 - i);
         #0.1;
         check($sformatf("async_clr_p1_%0d", i), bus.ReadData1, 64'h0);
         check($sformatf("async_clr_p2_%0d", 31 - i), bus.ReadData2, 64'h0);
      end
      reset = 1'b0;
      bus.WriteRegister = 5'd3;
      bus.WriteData = 64'h55;
      bus.RegWrite = 1'b1;
      tick();
      bus.RegWrite = 1'b0;
      bus.ReadRegister1 = 5'd3;
      bus.ReadRegister2 = 5'd30;
      #1;
      check("post_reset_x3", bus.ReadData1, 64'h55);
      check("post_reset_x30", bus.ReadData2, 64'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
